// File: rtl/ps2_key_tracker_if.sv
// Key-event handshake bundle between a PS/2 scan decoder (master) and the key tracker (slave).
interface ps2_key_if #(
  parameter int CODE_W = 8
);
  logic              key_valid;
  logic              key_ready;
  logic [CODE_W-1:0] keycode;
  logic              press;

  modport master (output key_valid, keycode, press, input key_ready);
  modport slave  (input key_valid, keycode, press, output key_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// Held-key table: records pressed keycodes in slots, drops them on release.
// Define KEY_TRACKER_COMPACT_EN to shift later slots down on release so held keys stay packed from slot 0.
module ps2_key_tracker #(
  parameter int NUM_SLOTS = 4,
  parameter int CODE_W = 8,
  localparam int CNT_W = $clog2(NUM_SLOTS + 1),
  localparam int PTR_W = $clog2(NUM_SLOTS)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        clear,
  ps2_key_if.slave                    key_bus,
  output logic [NUM_SLOTS*CODE_W-1:0] keycode_out,
  output logic [NUM_SLOTS-1:0]        held_mask,
  output logic [CNT_W-1:0]            key_count,
  output logic                        overflow
);

  logic [CODE_W-1:0]    slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] empty_vec;
  logic                 code_nz;
  logic                 accept;
  logic                 any_hit;
  logic                 any_empty;
  logic [PTR_W-1:0]     hit_idx;
  logic [PTR_W-1:0]     free_idx;

  // Code 0 means "empty", so it can never hit and is ignored once accepted.
  assign code_nz = |key_bus.keycode;
  assign accept  = key_bus.key_valid && key_bus.key_ready && !clear && code_nz;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign hit_vec[gi]   = code_nz && (slots[gi] == key_bus.keycode);
      assign empty_vec[gi] = (slots[gi] == '0);
      assign held_mask[gi] = ~empty_vec[gi];
      assign keycode_out[gi*CODE_W +: CODE_W] = slots[gi];
    end
  endgenerate

  assign any_hit   = |hit_vec;
  assign any_empty = |empty_vec;

  // Downward scan leaves the lowest matching / lowest empty index.
  always_comb begin
    hit_idx   = '0;
    free_idx  = '0;
    key_count = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i])   hit_idx  = PTR_W'(i);
      if (empty_vec[i]) free_idx = PTR_W'(i);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      key_count = key_count + CNT_W'(held_mask[i]);
    end
  end

`ifdef KEY_TRACKER_COMPACT_EN

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic              ready_reg;
  logic [CODE_W-1:0] next_code;
  logic              ptr_last;

  // Slot above ptr; the top slot has nothing above it.
  always_comb begin
    next_code = '0;
    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
      if (ptr_reg == PTR_W'(i)) next_code = slots[i+1];
    end
  end

  assign ptr_last          = (ptr_reg == PTR_W'(NUM_SLOTS - 1));
  assign key_bus.key_ready = ready_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      overflow  <= 1'b0;
      state_reg <= IDLE;
      ptr_reg   <= '0;
      ready_reg <= 1'b1;
    end else if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      overflow  <= 1'b0;
      state_reg <= IDLE;
      ptr_reg   <= '0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (key_bus.press) begin
              if (!any_hit) begin
                if (any_empty) slots[free_idx] <= key_bus.keycode;
                else           overflow        <= 1'b1;
              end
            end else if (any_hit) begin
              ptr_reg   <= hit_idx;
              state_reg <= SHIFT;
              ready_reg <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (ptr_last || next_code == '0) begin
            slots[ptr_reg] <= '0;
            state_reg      <= IDLE;
            ready_reg      <= 1'b1;
          end else begin
            slots[ptr_reg] <= next_code;
            ptr_reg        <= ptr_reg + PTR_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

`else

  assign key_bus.key_ready = 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (key_bus.press) begin
        if (!any_hit) begin
          if (any_empty) slots[free_idx] <= key_bus.keycode;
          else           overflow        <= 1'b1;
        end
      end else if (any_hit) begin
        slots[hit_idx] <= '0;
      end
    end
  end

`endif

endmodule
